// File: rtl/mvau_weight_streamer.sv
`default_nettype none
// ============================================================================
// Module   : mvau_weight_streamer
// Brief    : Run-time loadable multi-bank MVAU weight memory. Weights load over
//            AXI-Stream and stream back out with wrapping addressing.
// Revision : 1.0 - initial release
// ============================================================================
module mvau_weight_streamer #(
    parameter int PE           = 2,
    parameter int SIMD         = 2,
    parameter int TW           = 4,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      load_start,
    input  logic                      strm_en,
    output logic                      load_done,
    output logic                      busy,
    input  logic                      s_wld_tvalid,
    output logic                      s_wld_tready,
    input  logic [SIMD*TW-1:0]        s_wld_tdata,
    output logic                      m_wgt_tvalid,
    input  logic                      m_wgt_tready,
    output logic [PE*SIMD*TW-1:0]     m_wgt_tdata,
    output logic                      m_wgt_tlast
);

    localparam int c_WORD_W  = SIMD * TW;
    localparam int c_VEC_W   = PE * c_WORD_W;
    localparam int c_BANK_BW = (PE > 1) ? $clog2(PE) : 1;
    localparam logic [c_BANK_BW-1:0]    c_LAST_BANK = c_BANK_BW'(PE - 1);
    localparam logic [WMEM_ADDR_BW-1:0] c_LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [c_BANK_BW-1:0]      r_ld_bank;
    logic [WMEM_ADDR_BW-1:0]   r_ld_addr;
    logic                      r_load_done;
    logic [WMEM_ADDR_BW-1:0]   r_rd_addr;
    logic                      r_rd_vld;
    logic                      r_rd_last;
    logic [c_VEC_W-1:0]        w_rd_data;
    logic [c_VEC_W-1:0]        r_fifo_data [2];
    logic [1:0]                r_fifo_last;
    logic                      r_wptr;
    logic                      r_rptr;
    logic [1:0]                r_fifo_cnt;
    logic                      w_ld_hs;
    logic                      w_ld_last;
    logic                      w_pop;
    logic                      w_issue;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        busy         = (r_state != S_IDLE);
        s_wld_tready = (r_state == S_LOAD);
        case (r_state)
            S_IDLE: begin
                if (load_start) begin
                    w_state_nxt = S_LOAD;
                end else if (strm_en) begin
                    w_state_nxt = S_STREAM;
                end
            end
            S_LOAD:   if (w_ld_last) w_state_nxt = S_IDLE;
            S_STREAM: if (!strm_en) w_state_nxt = S_DRAIN;
            S_DRAIN:  if (!r_rd_vld && (r_fifo_cnt == 2'd0)) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- Load path
    assign w_ld_hs   = s_wld_tready && s_wld_tvalid;
    assign w_ld_last = w_ld_hs && (r_ld_bank == c_LAST_BANK) && (r_ld_addr == c_LAST_ADDR);
    assign load_done = r_load_done;

    // Beats rotate across banks first, so beat k lands in bank k%PE, word k/PE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ld_bank   <= '0;
            r_ld_addr   <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_ld_last;
            if (r_state != S_LOAD) begin
                r_ld_bank <= '0;
                r_ld_addr <= '0;
            end else if (w_ld_hs) begin
                if (r_ld_bank == c_LAST_BANK) begin
                    r_ld_bank <= '0;
                    r_ld_addr <= (r_ld_addr == c_LAST_ADDR) ? '0 : r_ld_addr + 1'b1;
                end else begin
                    r_ld_bank <= r_ld_bank + 1'b1;
                end
            end
        end
    end

    // ----------------------------------------------------------- Bank RAMs
    for (genvar p = 0; p < PE; p++) begin : g_bank
        logic [c_WORD_W-1:0] r_mem [WMEM_DEPTH];
        logic [c_WORD_W-1:0] r_rd_word;

        always_ff @(posedge aclk) begin
            if (w_ld_hs && (r_ld_bank == c_BANK_BW'(p))) begin
                r_mem[r_ld_addr] <= s_wld_tdata;
            end
            if (w_issue) begin
                r_rd_word <= r_mem[r_rd_addr];
            end
        end

        assign w_rd_data[p*c_WORD_W +: c_WORD_W] = r_rd_word;
    end

    // ------------------------------------------------------------ Read path
    // A beat leaving this cycle frees its slot in time for a read issued now,
    // which is what keeps a 2-entry buffer at one beat per cycle.
    assign w_pop   = m_wgt_tvalid && m_wgt_tready;
    assign w_issue = (r_state == S_STREAM) && strm_en &&
                     ((3'(r_fifo_cnt) + 3'(r_rd_vld)) < (3'd2 + 3'(w_pop)));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_last <= 1'b0;
        end else begin
            r_rd_vld <= w_issue;
            if (w_issue) begin
                r_rd_last <= (r_rd_addr == c_LAST_ADDR);
                r_rd_addr <= (r_rd_addr == c_LAST_ADDR) ? '0 : r_rd_addr + 1'b1;
            end else if (r_state != S_STREAM) begin
                r_rd_addr <= '0;
            end
        end
    end

    // ------------------------------------------------------- Output skid FIFO
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
            end
            r_fifo_last <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_fifo_cnt  <= 2'd0;
        end else begin
            if (r_rd_vld) begin
                r_fifo_data[r_wptr] <= w_rd_data;
                r_fifo_last[r_wptr] <= r_rd_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({r_rd_vld, w_pop})
                2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
                2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
                default: r_fifo_cnt <= r_fifo_cnt;
            endcase
        end
    end

    assign m_wgt_tvalid = (r_fifo_cnt != 2'd0);
    assign m_wgt_tdata  = r_fifo_data[r_rptr];
    assign m_wgt_tlast  = r_fifo_last[r_rptr];

endmodule
`default_nettype wire
